fp32_mul_seq: RTL and testbench
===============================

Name: fp32_mul_seq

Overview:
Iterative IEEE-754 single-precision multiplier that sits directly downstream of the integer-to-FP32 converter and consumes its packed fp32 results. It accepts two fp32 operands over a valid/ready handshake and forms the 24x24 significand product with a shift-add datapath, one bit per cycle. It then normalises and rounds to nearest-even. It returns the packed result with Exception/Overflow/Underflow flags, using the same flag semantics as the converter.

Parameters:
EXC_QNAN, 0, 1: Exception result is canonical qNaN 32'h7FC00000; 0: Exception result is {sign, 8'hFF, 23'd0}

Ports:
clk        input   1   rising-edge clock
rst        input   1   reset, synchronous, active-high
in_valid   input   1   operands a/b valid
in_ready   output  1   block can accept operands
a          input   32  fp32 operand A
b          input   32  fp32 operand B
out_valid  output  1   result/flags valid
out_ready  input   1   consumer accepts result
result     output  32  fp32 product
Exception  output  1   operand exponent == 8'hFF (Inf/NaN)
Overflow   output  1   product exponent >= 255
Underflow  output  1   product exponent <= 0 with nonzero operands
busy       output  1   state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all flags 0.
- Reset mid-operation: the operation is discarded. Next cycle is IDLE with in_ready=1 and out_valid=0.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - in_ready is 1 only in IDLE.
  - Output transfer occurs when out_valid & out_ready.
  - result and flags stay stable while out_valid=1 and out_ready=0.
- FSM: IDLE -> MUL -> NORM -> DONE -> IDLE.
  - IDLE: on accept, latch sign=a[31]^b[31], ea, eb, ma={1,a[22:0]}, mb={1,b[22:0]}.
  - IDLE, operand classification at accept:
    - Either exponent == 8'hFF: go directly to DONE with Exception=1.
    - Else either exponent == 0 (zero/denormal, flushed to zero): go directly to DONE, result={sign,31'd0}, no flags.
    - Else go to MUL.
  - MUL: 48-bit accumulator. Each cycle, if the current multiplier LSB is 1, add the shifted multiplicand. Bit counter runs 0..23; exit after 24 cycles.
  - NORM: one cycle; normalise, round, compute the exponent and register outputs.
  - DONE: out_valid=1. On out_ready, go to IDLE with out_valid=0 in the next cycle.
- Latency, with accept in cycle T:
  - Normal path: MUL in T+1..T+24, NORM in T+25, out_valid high from T+26.
  - Exception and zero paths: out_valid high from T+1.
  - No back-to-back acceptance: the next accept occurs no earlier than the cycle after the output transfer.
- Normalise and round, with product P[47:0]:
  - If P[47]=1: mant=P[46:24], G=P[23], S=|P[22:0], n=1.
  - Else: mant=P[45:23], G=P[22], S=|P[21:0], n=0.
  - round_up = G & (S | mant[0]).
  - On round carry-out: mant=0 and exponent +1.
- Exponent: e = ea + eb - 127 + n + carry, computed signed, 10 bits wide.
  - e >= 255: Overflow=1, result={sign,8'hFF,23'd0}.
  - e <= 0: Underflow=1, result={sign,31'd0}. No denormal outputs.
  - Otherwise: result={sign,e[7:0],mant}.
- Flag exclusivity: flags are mutually exclusive. Exception takes priority over the zero path, e.g. Inf*0 gives Exception=1.

Optional Feature:
FP32_MUL_RADIX4_EN
- Defined: MUL retires 2 multiplier bits per cycle, adding 0, 1x, 2x or 3x the multiplicand; 3x is precomputed in IDLE. MUL takes 12 cycles and out_valid is high from T+14.
- Undefined: radix-2 datapath, 24 MUL cycles, out_valid high from T+26.
- Results and flags are bit-identical in both configurations.

Test Plan:
- Basic and latency: a=32'h40400000 (3.0), b=32'h40000000 (2.0), out_ready=1 -> result=32'h40C00000, no flags, out_valid at T+26 (T+14 with FP32_MUL_RADIX4_EN).
- Sign and normalise (n=1): a=32'hC0400000, b=32'h40000000 -> result=32'hC0C00000. a=b=32'h3FC00000 -> result=32'h40100000.
- Rounding (sticky path): a=b=32'h3F800001 -> result=32'h3F800002.
- Overflow/underflow: a=b=32'h7F000000 -> result=32'h7F800000, Overflow=1. a=b=32'h00800000 -> result=32'h00000000, Underflow=1.
- Exception/zero fast path:
  - a=32'h7F800000, b=32'h3F800000 -> Exception=1 at T+1; result=32'h7F800000 (EXC_QNAN=0) or 32'h7FC00000 (EXC_QNAN=1).
  - a=0, b=32'h40000000 -> result=0, no flags, at T+1.
- Backpressure and reset: hold out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready=0. Assert rst at T+5 -> next cycle out_valid=0, in_ready=1, busy=0.

Source files
------------

// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq -- iterative IEEE-754 single-precision multiplier.
//
// Takes two packed fp32 operands over a valid/ready handshake. The 24x24
// significand product is built by a shift-add datapath, then normalised
// and rounded to nearest-even in a single cycle. Denormal operands are
// flushed to zero and denormal results are never produced.
//
// Build option:
//   FP32_MUL_RADIX4_EN  when defined, MUL retires two multiplier bits per
//                       cycle (12 MUL cycles instead of 24). Results and
//                       flags are identical in both builds.
//
// Parameter:
//   EXC_QNAN   1: exception result is canonical qNaN 32'h7FC00000
//              0: exception result is {sign, 8'hFF, 23'd0}
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b)
//   out_valid / out_ready result handshake (result + flags)
//   result                packed fp32 product
//   Exception             an operand had exponent 8'hFF
//   Overflow              product exponent >= 255
//   Underflow             product exponent <= 0 with nonzero operands
//   busy                  FSM is not in IDLE
//
// Handshake: a transfer happens on any rising edge where valid & ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and result/flags hold their value until the cycle after out_ready is seen.

module fp32_mul_seq #(
    parameter bit EXC_QNAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

`ifdef FP32_MUL_RADIX4_EN
    localparam logic [4:0] LAST_CNT = 5'd11;
`else
    localparam logic [4:0] LAST_CNT = 5'd23;
`endif

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
`ifdef FP32_MUL_RADIX4_EN
    logic [47:0] mcand3_q, mcand3_d;
`endif

    // Operand decode at the input port (only meaningful in IDLE).
    logic        in_sign;
    logic        in_exc;
    logic        in_zero;
    logic [31:0] exc_result;
    logic [23:0] in_ma;

    always_comb begin
        in_sign    = a[31] ^ b[31];
        in_exc     = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        in_zero    = (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
        exc_result = EXC_QNAN ? 32'h7FC0_0000 : {in_sign, 8'hFF, 23'd0};
        in_ma      = {1'b1, a[22:0]};
    end

    // Normalise / round / exponent from the finished product in acc_q.
    logic [22:0] mant_pre;
    logic        guard_bit;
    logic        sticky_bit;
    logic        norm_n;
    logic        round_up;
    logic [23:0] mant_rnd;
    logic        rnd_carry;
    logic [22:0] mant_fin;
    logic [9:0]  exp_sum;
    logic        exp_ovf;
    logic        exp_unf;

    always_comb begin
        norm_n = acc_q[47];
        if (acc_q[47]) begin
            mant_pre   = acc_q[46:24];
            guard_bit  = acc_q[23];
            sticky_bit = |acc_q[22:0];
        end else begin
            mant_pre   = acc_q[45:23];
            guard_bit  = acc_q[22];
            sticky_bit = |acc_q[21:0];
        end
        round_up  = guard_bit & (sticky_bit | mant_pre[0]);
        mant_rnd  = {1'b0, mant_pre} + {23'd0, round_up};
        rnd_carry = mant_rnd[23];
        // A carry out of the rounder means the mantissa was all ones; the
        // rounded significand is exactly 2.0, so the fraction becomes zero.
        mant_fin  = rnd_carry ? 23'd0 : mant_rnd[22:0];
        // 10-bit two's complement: range is -125..383, so no wrap.
        exp_sum   = {2'b00, ea_q} + {2'b00, eb_q} + {9'd0, norm_n}
                  + {9'd0, rnd_carry} - 10'd127;
        exp_ovf   = $signed(exp_sum) >= 10'sd255;
        exp_unf   = $signed(exp_sum) <= 10'sd0;
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
`ifdef FP32_MUL_RADIX4_EN
        mcand3_d = mcand3_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    ea_d     = a[30:23];
                    eb_d     = b[30:23];
                    mcand_d  = {24'd0, in_ma};
                    mplier_d = {1'b1, b[22:0]};
                    acc_d    = 48'd0;
                    cnt_d    = 5'd0;
`ifdef FP32_MUL_RADIX4_EN
                    mcand3_d = {24'd0, in_ma} + {23'd0, in_ma, 1'b0};
`endif
                    // Inf/NaN wins over zero, so Inf*0 reports Exception.
                    if (in_exc) begin
                        result_d = exc_result;
                        exc_d    = 1'b1;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        state_d  = DONE;
                    end else if (in_zero) begin
                        result_d = {in_sign, 31'd0};
                        exc_d    = 1'b0;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d  = MUL;
                    end
                end
            end

            MUL: begin
`ifdef FP32_MUL_RADIX4_EN
                case (mplier_q[1:0])
                    2'b01:   acc_d = acc_q + mcand_q;
                    2'b10:   acc_d = acc_q + {mcand_q[46:0], 1'b0};
                    2'b11:   acc_d = acc_q + mcand3_q;
                    default: acc_d = acc_q;
                endcase
                mcand_d  = {mcand_q[45:0], 2'b00};
                mcand3_d = {mcand3_q[45:0], 2'b00};
                mplier_d = {2'b00, mplier_q[23:2]};
`else
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[46:0], 1'b0};
                mplier_d = {1'b0, mplier_q[23:1]};
`endif
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = NORM;
                end
            end

            NORM: begin
                exc_d = 1'b0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
                if (exp_ovf) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (exp_unf) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_sum[7:0], mant_fin};
                end
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            acc_q    <= 48'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`ifdef FP32_MUL_RADIX4_EN
            mcand3_q <= 48'd0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`ifdef FP32_MUL_RADIX4_EN
            mcand3_q <= mcand3_d;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = result_q;
        Exception = exc_q;
        Overflow  = ovf_q;
        Underflow = unf_q;
    end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed testbench for fp32_mul_seq: reset state, arithmetic vectors,
// rounding, overflow/underflow, exception/zero fast path, backpressure and
// reset during an operation.

module tb_fp32_mul_seq;

    localparam bit EXC_QNAN = 1'b0;
`ifdef FP32_MUL_RADIX4_EN
    localparam int EXP_LAT = 14;
`else
    localparam int EXP_LAT = 26;
`endif
    localparam logic [31:0] EXC_POS = EXC_QNAN ? 32'h7FC0_0000 : 32'h7F80_0000;
    localparam logic [31:0] EXC_NEG = EXC_QNAN ? 32'h7FC0_0000 : 32'hFF80_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fp32_mul_seq #(.EXC_QNAN(EXC_QNAN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- drivers ----------------
    // Present one operand pair, then count cycles from the accept edge
    // (cycle T+1 is the first sample) until out_valid; result stays held.
    task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v,
                          output int lat, output logic [31:0] res,
                          output logic [2:0] flg);
        int wait_cnt;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 100) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        a = a_v;
        b = b_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        flg = {Exception, Overflow, Underflow};
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b%b%b want 100",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (result !== 32'd0 || {Exception, Overflow, Underflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_data: result=%h flags=%b want 00000000 000",
                     result, {Exception, Overflow, Underflow});
        end
    endtask

    // Shared vector table walker with inline comparisons per test.
    task automatic test_vectors(input string name, input int n,
                                input logic [31:0] va[8], input logic [31:0] vb[8],
                                input logic [31:0] vr[8], input logic [2:0] vf[8],
                                input int vl[8]);
        int lat;
        logic [31:0] res;
        logic [2:0]  flg;
        for (int i = 0; i < n; i++) begin
            run_op(va[i], vb[i], lat, res, flg);
            checks++;
            if (lat !== vl[i]) begin
                errors++;
                $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, vl[i]);
            end
            checks++;
            if (res !== vr[i]) begin
                errors++;
                $display("FAIL %s[%0d] result: %h*%h got %h want %h",
                         name, i, va[i], vb[i], res, vr[i]);
            end
            checks++;
            if (flg !== vf[i]) begin
                errors++;
                $display("FAIL %s[%0d] flags(E,O,U): got %b want %b", name, i, flg, vf[i]);
            end
            drain();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] release: out_valid=%b in_ready=%b want 0 1",
                         name, i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] va[8] = '{32'h4040_0000, 32'hC040_0000, 32'h3FC0_0000,
                               32'h3F80_0001, 32'h3FC0_0000, 32'h3FA1_E58F, 0, 0};
        logic [31:0] vb[8] = '{32'h4000_0000, 32'h4000_0000, 32'h3FC0_0000,
                               32'h3F80_0001, 32'h3F80_0001, 32'h3FCA_6691, 0, 0};
        logic [31:0] vr[8] = '{32'h40C0_0000, 32'hC0C0_0000, 32'h4010_0000,
                               32'h3F80_0002, 32'h3FC0_0002, 32'h4000_0000, 0, 0};
        logic [2:0]  vf[8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0};
        int          vl[8] = '{EXP_LAT, EXP_LAT, EXP_LAT, EXP_LAT, EXP_LAT, EXP_LAT, 0, 0};
        test_vectors("arith", 6, va, vb, vr, vf, vl);
    endtask

    task automatic test_ovf_unf();
        logic [31:0] va[8] = '{32'h7F00_0000, 32'h0080_0000, 32'hFF00_0000, 0, 0, 0, 0, 0};
        logic [31:0] vb[8] = '{32'h7F00_0000, 32'h0080_0000, 32'h7F00_0000, 0, 0, 0, 0, 0};
        logic [31:0] vr[8] = '{32'h7F80_0000, 32'h0000_0000, 32'hFF80_0000, 0, 0, 0, 0, 0};
        logic [2:0]  vf[8] = '{3'b010, 3'b001, 3'b010, 0, 0, 0, 0, 0};
        int          vl[8] = '{EXP_LAT, EXP_LAT, EXP_LAT, 0, 0, 0, 0, 0};
        test_vectors("ovf_unf", 3, va, vb, vr, vf, vl);
    endtask

    task automatic test_fast_path();
        logic [31:0] va[8] = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000,
                               32'h8000_0000, 32'hFF80_0000, 0, 0, 0};
        logic [31:0] vb[8] = '{32'h3F80_0000, 32'h4000_0000, 32'h0000_0000,
                               32'h4000_0000, 32'h3F80_0000, 0, 0, 0};
        logic [31:0] vr[8] = '{EXC_POS, 32'h0000_0000, EXC_POS,
                               32'h8000_0000, EXC_NEG, 0, 0, 0};
        logic [2:0]  vf[8] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 0};
        int          vl[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        test_vectors("fast", 5, va, vb, vr, vf, vl);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res;
        logic [2:0]  flg;
        run_op(32'h4040_0000, 32'h4000_0000, lat, res, flg);
        checks++;
        if (res !== 32'h40C0_0000) begin
            errors++;
            $display("FAIL bp_first: result got %h want 40c00000", res);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (result !== 32'h40C0_0000 || {Exception, Overflow, Underflow} !== 3'b000
                || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: result=%h flags=%b out_valid=%b in_ready=%b want 40c00000 000 1 0",
                         i, result, {Exception, Overflow, Underflow}, out_valid, in_ready);
            end
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [31:0] res;
        logic [2:0]  flg;
        a = 32'h4040_0000;
        b = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        // Block must work normally after the aborted operation.
        run_op(32'hC040_0000, 32'h4000_0000, lat, res, flg);
        checks++;
        if (lat !== EXP_LAT || res !== 32'hC0C0_0000 || flg !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_op: lat=%0d result=%h flags=%b want %0d c0c00000 000",
                     lat, res, flg, EXP_LAT);
        end
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        apply_reset();
        test_reset();
        test_arith();
        test_ovf_unf();
        test_fast_path();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
